// File: rtl/main_control_fsm_pkg.sv
// rtl/main_control_fsm_pkg.sv - shared opcodes, ALU/mux codes, state encodings and control word for the MIPS main control
package main_control_fsm_pkg;

  localparam int OP_W = 6;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;

  // ALU_control decodes these same codes
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_RESET  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_ADDIEX = 4'd11,
    S_ADDIWB = 4'd12
  } state_t;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       illegal_op;
  } ctrl_word_t;

  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
  endfunction

endpackage

// File: rtl/main_control_fsm_if.sv
// rtl/main_control_fsm_if.sv - opcode/handshake inputs and datapath strobes between control FSM and datapath
interface main_control_fsm_if;

  logic [main_control_fsm_pkg::OP_W-1:0] opcode;
  logic       mem_ready;
  logic [1:0] ALUOp;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSource;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       illegal_op;
  logic [3:0] state_dbg;

  modport master (
    input  opcode, mem_ready,
    output ALUOp, ALUSrcA, ALUSrcB, PCSource, IorD, MemRead, MemWrite, IRWrite,
           RegDst, MemtoReg, RegWrite, PCWrite, PCWriteCond, illegal_op, state_dbg
  );

  modport slave (
    output opcode, mem_ready,
    input  ALUOp, ALUSrcA, ALUSrcB, PCSource, IorD, MemRead, MemWrite, IRWrite,
           RegDst, MemtoReg, RegWrite, PCWrite, PCWriteCond, illegal_op, state_dbg
  );

endinterface

// File: rtl/main_control_fsm_ctrl_word_decode.sv
// rtl/main_control_fsm_ctrl_word_decode.sv - combinational state/mem_ready/opcode to control word decode
module main_control_fsm_ctrl_word_decode
  import main_control_fsm_pkg::*;
(
  input  state_t              state,
  input  logic                mem_ready,
  input  logic [OP_W-1:0]     opcode,
  output ctrl_word_t          cw
);

  always_comb begin
    cw = '0;
    case (state)
      S_FETCH: begin
        cw.mem_read  = 1'b1;
        cw.iord      = 1'b0;
        cw.alu_src_a = 1'b0;
        cw.alu_src_b = SRCB_FOUR;
        cw.alu_op    = ALUOP_ADD;
        cw.pc_source = PCSRC_ALU;
        // IR and PC may only latch once the fetched word is actually valid
        cw.ir_write  = mem_ready;
        cw.pc_write  = mem_ready;
      end
      S_DECODE: begin
        cw.alu_src_b  = SRCB_IMM_SH2;
        cw.alu_op     = ALUOP_ADD;
        cw.illegal_op = !is_legal_op(opcode);
      end
      S_MEMADR, S_ADDIEX: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = SRCB_IMM;
        cw.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        cw.mem_read = 1'b1;
        cw.iord     = 1'b1;
      end
      S_MEMWB: begin
        cw.reg_write  = 1'b1;
        cw.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        cw.mem_write = 1'b1;
        cw.iord      = 1'b1;
      end
      S_EXEC: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = SRCB_REGB;
        cw.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        cw.reg_write = 1'b1;
        cw.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        cw.alu_src_a     = 1'b1;
        cw.alu_src_b     = SRCB_REGB;
        cw.alu_op        = ALUOP_SUB;
        cw.pc_write_cond = 1'b1;
        cw.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        cw.pc_write  = 1'b1;
        cw.pc_source = PCSRC_JUMP;
      end
      S_ADDIWB: begin
        cw.reg_write = 1'b1;
      end
      default: cw = '0;
    endcase
  end

endmodule

// File: rtl/main_control_fsm.sv
// rtl/main_control_fsm.sv - multicycle MIPS main control: state register and next-state sequencing
module main_control_fsm
  import main_control_fsm_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  main_control_fsm_if.master   bus
);

  state_t     state;
  state_t     state_nx;
  ctrl_word_t cw;

  main_control_fsm_ctrl_word_decode u_decode (
    .state     (state),
    .mem_ready (bus.mem_ready),
    .opcode    (bus.opcode),
    .cw        (cw)
  );

  always_comb begin
    state_nx = S_RESET;
    case (state)
      S_RESET:  state_nx = S_FETCH;
      S_FETCH:  state_nx = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: state_nx = S_MEMADR;
          OP_RTYPE:     state_nx = S_EXEC;
          OP_BEQ:       state_nx = S_BRANCH;
          OP_J:         state_nx = S_JUMP;
          OP_ADDI:      state_nx = S_ADDIEX;
          default:      state_nx = S_FETCH;
        endcase
      end
      S_MEMADR: state_nx = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_nx = bus.mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_nx = S_FETCH;
      S_MEMWR:  state_nx = bus.mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_nx = S_ALUWB;
      S_ALUWB:  state_nx = S_FETCH;
      S_BRANCH: state_nx = S_FETCH;
      S_JUMP:   state_nx = S_FETCH;
      S_ADDIEX: state_nx = S_ADDIWB;
      S_ADDIWB: state_nx = S_FETCH;
      default:  state_nx = S_RESET;
    endcase
  end

  // Async reset lands in S_RESET, whose decoded word is all zero, so strobes drop immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_RESET;
    end else begin
      state <= state_nx;
    end
  end

  assign bus.ALUOp       = cw.alu_op;
  assign bus.ALUSrcA     = cw.alu_src_a;
  assign bus.ALUSrcB     = cw.alu_src_b;
  assign bus.PCSource    = cw.pc_source;
  assign bus.IorD        = cw.iord;
  assign bus.MemRead     = cw.mem_read;
  assign bus.MemWrite    = cw.mem_write;
  assign bus.IRWrite     = cw.ir_write;
  assign bus.RegDst      = cw.reg_dst;
  assign bus.MemtoReg    = cw.mem_to_reg;
  assign bus.RegWrite    = cw.reg_write;
  assign bus.PCWrite     = cw.pc_write;
  assign bus.PCWriteCond = cw.pc_write_cond;
  assign bus.illegal_op  = cw.illegal_op;
  assign bus.state_dbg   = state;

endmodule
